// File: rtl/alu_ctrl_seq.sv
// Microprogrammed control sequencer for the 8-bit bus CPU: one-hot T-state ring,
// per-opcode control decode, carry flag capture and sticky halt.
module alu_ctrl_seq #(
    parameter int unsigned OPC_W     = 4,
    parameter bit          EARLY_END = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             alu_cout,
    output logic             pc_out_en,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mar_load,
    output logic             ram_out_en,
    output logic             ir_load,
    output logic             ir_out_en,
    output logic             a_load,
    output logic             a_out_en,
    output logic             b_load,
    output logic             alu_sub,
    output logic             alu_out_en,
    output logic             out_load,
    output logic             carry_flag,
    output logic             halted,
    output logic [5:0]       t_state
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'b0000);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'b0001);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'b0010);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'b0110);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'b0111);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'b1110);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'b1111);

    logic [5:0] t_state_q, t_state_d, last_state;
    logic       carry_q, carry_d;
    logic       halted_q, halted_d;
    logic       is_addsub;

    always_comb begin
        is_addsub = (opcode == OP_ADD) || (opcode == OP_SUB);
        if (opcode == OP_LDA) begin
            last_state = T5;
        end else if (is_addsub) begin
            last_state = T6;
        end else begin
            last_state = T4;
        end

        t_state_d = t_state_q;
        carry_d   = carry_q;
        halted_d  = halted_q;
        if (!$onehot(t_state_q)) begin
            t_state_d = T1;
        end else if (run && !halted_q) begin
            // HLT freezes the ring at T4; the halted flag gates everything from then on
            if (t_state_q == T4 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else if (EARLY_END && t_state_q == last_state) begin
                t_state_d = T1;
            end else begin
                t_state_d = {t_state_q[4:0], t_state_q[5]};
            end
            if (t_state_q == T6 && is_addsub) begin
                carry_d = alu_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_state_q <= T1;
            carry_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            carry_q   <= carry_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        pc_out_en  = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mar_load   = 1'b0;
        ram_out_en = 1'b0;
        ir_load    = 1'b0;
        ir_out_en  = 1'b0;
        a_load     = 1'b0;
        a_out_en   = 1'b0;
        b_load     = 1'b0;
        alu_sub    = 1'b0;
        alu_out_en = 1'b0;
        out_load   = 1'b0;
        if (rst_n && !halted_q) begin
            case (t_state_q)
                T1: begin
                    pc_out_en = 1'b1;
                    mar_load  = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_out_en = 1'b1;
                    ir_load    = 1'b1;
                end
                T4: begin
                    if (opcode == OP_LDA || is_addsub) begin
                        ir_out_en = 1'b1;
                        mar_load  = 1'b1;
                    end else if (opcode == OP_JMP || (opcode == OP_JC && carry_q)) begin
                        ir_out_en = 1'b1;
                        pc_load   = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        a_out_en = 1'b1;
                        out_load = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ram_out_en = 1'b1;
                        a_load     = 1'b1;
                    end else if (is_addsub) begin
                        ram_out_en = 1'b1;
                        b_load     = 1'b1;
                    end
                end
                T6: begin
                    if (is_addsub) begin
                        alu_out_en = 1'b1;
                        a_load     = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state    = t_state_q;
    assign carry_flag = carry_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: a table of fetch/execute cycles with hand-computed
// controls, plus hand sequences for run hold, halt, reset and EARLY_END = 0.
module tb_alu_ctrl_seq;

    localparam logic [12:0] PCO  = 13'h1000;
    localparam logic [12:0] PCI  = 13'h0800;
    localparam logic [12:0] PCL  = 13'h0400;
    localparam logic [12:0] MARL = 13'h0200;
    localparam logic [12:0] RAMO = 13'h0100;
    localparam logic [12:0] IRL  = 13'h0080;
    localparam logic [12:0] IRO  = 13'h0040;
    localparam logic [12:0] AL   = 13'h0020;
    localparam logic [12:0] AO   = 13'h0010;
    localparam logic [12:0] BL   = 13'h0008;
    localparam logic [12:0] SUB  = 13'h0004;
    localparam logic [12:0] ALUO = 13'h0002;
    localparam logic [12:0] OUTL = 13'h0001;
    localparam logic [12:0] BUS  = PCO | RAMO | IRO | AO | ALUO;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic clk = 1'b0;
    logic rst_n, run, alu_cout;
    logic [3:0] opcode;

    logic [12:0] ctrl0, ctrl1;
    logic [5:0]  ts0, ts1;
    logic        carry0, carry1, halted0, halted1;

    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic        cout;
        logic [5:0]  ts;
        logic [12:0] ctrl;
        logic        carry;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    alu_ctrl_seq #(.OPC_W(4), .EARLY_END(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_cout(alu_cout),
        .pc_out_en(ctrl0[12]), .pc_inc(ctrl0[11]), .pc_load(ctrl0[10]), .mar_load(ctrl0[9]),
        .ram_out_en(ctrl0[8]), .ir_load(ctrl0[7]), .ir_out_en(ctrl0[6]), .a_load(ctrl0[5]),
        .a_out_en(ctrl0[4]), .b_load(ctrl0[3]), .alu_sub(ctrl0[2]), .alu_out_en(ctrl0[1]),
        .out_load(ctrl0[0]), .carry_flag(carry0), .halted(halted0), .t_state(ts0)
    );

    alu_ctrl_seq #(.OPC_W(4), .EARLY_END(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_cout(alu_cout),
        .pc_out_en(ctrl1[12]), .pc_inc(ctrl1[11]), .pc_load(ctrl1[10]), .mar_load(ctrl1[9]),
        .ram_out_en(ctrl1[8]), .ir_load(ctrl1[7]), .ir_out_en(ctrl1[6]), .a_load(ctrl1[5]),
        .a_out_en(ctrl1[4]), .b_load(ctrl1[3]), .alu_sub(ctrl1[2]), .alu_out_en(ctrl1[1]),
        .out_load(ctrl1[0]), .carry_flag(carry1), .halted(halted1), .t_state(ts1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic cout, input logic [5:0] ts,
                        input logic [12:0] ctrl, input logic carry);
        vec_t v;
        v.op = op; v.cout = cout; v.ts = ts; v.ctrl = ctrl; v.carry = carry;
        vq.push_back(v);
    endtask

    // One instruction with EARLY_END = 1; carry is constant across it (captured at the T6 edge)
    task automatic add_instr(input logic [3:0] op, input logic cout6, input logic cin,
                             input logic [12:0] e4, input logic [12:0] e5,
                             input logic [12:0] e6, input int last);
        push(op, 1'b0, T1, PCO | MARL, cin);
        push(op, 1'b0, T2, PCI, cin);
        push(op, 1'b0, T3, RAMO | IRL, cin);
        push(op, 1'b0, T4, e4, cin);
        if (last >= 5) push(op, 1'b0, T5, e5, cin);
        if (last >= 6) push(op, cout6, T6, e6, cin);
    endtask

    // Bus contention and one-hot state on both instances, every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ($countones(ctrl0 & BUS) > 1 || $countones(ctrl1 & BUS) > 1 ||
                !$onehot(ts0) || !$onehot(ts1)) begin
                bad++;
                $display("FAIL bus_onehot ctrl0=%h ctrl1=%h ts0=%b ts1=%b",
                         ctrl0, ctrl1, ts0, ts1);
            end
        end
    end

    initial begin
        logic [12:0] ee0_exp [7];
        logic [5:0]  ee0_ts  [7];

        rst_n = 1'b0; run = 1'b1; opcode = 4'h0; alu_cout = 1'b0;
        step();
        chk("rst_ctrl", 32'(ctrl0), 32'(0));
        step();
        chk("rst_ts", 32'(ts0), 32'(T1));
        chk("rst_halted", 32'({carry0, halted0}), 32'(0));
        rst_n = 1'b1;
        mon_en = 1'b1;

        add_instr(4'h0, 1'b0, 1'b0, IRO | MARL, RAMO | AL, 13'h0, 5);           // LDA
        add_instr(4'h1, 1'b1, 1'b0, IRO | MARL, RAMO | BL, ALUO | AL, 6);       // ADD c=1
        add_instr(4'h2, 1'b0, 1'b1, IRO | MARL, RAMO | BL, ALUO | AL | SUB, 6); // SUB c=0
        add_instr(4'h7, 1'b0, 1'b0, 13'h0, 13'h0, 13'h0, 4);                   // JC not taken
        add_instr(4'h2, 1'b1, 1'b0, IRO | MARL, RAMO | BL, ALUO | AL | SUB, 6); // SUB c=1
        add_instr(4'h7, 1'b0, 1'b1, IRO | PCL, 13'h0, 13'h0, 4);               // JC taken
        add_instr(4'h6, 1'b0, 1'b1, IRO | PCL, 13'h0, 13'h0, 4);               // JMP
        add_instr(4'he, 1'b0, 1'b1, AO | OUTL, 13'h0, 13'h0, 4);               // OUT
        add_instr(4'h3, 1'b0, 1'b1, 13'h0, 13'h0, 13'h0, 4);                   // NOP

        for (int i = 0; i < vq.size(); i++) begin
            opcode = vq[i].op;
            alu_cout = vq[i].cout;
            #1;
            chk($sformatf("vec%0d_ts", i), 32'(ts0), 32'(vq[i].ts));
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl0), 32'(vq[i].ctrl));
            chk($sformatf("vec%0d_carry", i), 32'(carry0), 32'(vq[i].carry));
            step();
        end
        alu_cout = 1'b0;
        chk("after_nop_ts", 32'(ts0), 32'(T1));

        // Run hold in T5 of ADD
        opcode = 4'h1;
        repeat (4) step();
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d", k), 32'({ts0, ctrl0}), 32'({T5, RAMO | BL}));
            step();
        end
        chk("hold_end", 32'({ts0, ctrl0}), 32'({T5, RAMO | BL}));
        run = 1'b1;
        step();
        chk("resume_t6", 32'({ts0, ctrl0}), 32'({T6, ALUO | AL}));
        step();
        chk("resume_t1_carry", 32'({ts0, carry0}), 32'({T1, 1'b0}));

        // HLT
        opcode = 4'hf;
        repeat (3) step();
        chk("hlt_t4", 32'({ts0, ctrl0, halted0}), 32'({T4, 13'h0, 1'b0}));
        step();
        chk("hlt_set", 32'({ts0, halted0}), 32'({T4, 1'b1}));
        for (int k = 0; k < 12; k++) begin
            run = k[0];
            step();
            chk($sformatf("halted%0d", k), 32'({ts0, ctrl0, halted0}), 32'({T4, 13'h0, 1'b1}));
        end
        run = 1'b1;
        rst_n = 1'b0;
        step();
        chk("hlt_rst", 32'({ts0, ctrl0, halted0}), 32'({T1, 13'h0, 1'b0}));
        rst_n = 1'b1;
        #1;
        chk("hlt_rst_t1", 32'(ctrl0), 32'(PCO | MARL));

        // Reset mid-instruction clears a set carry
        opcode = 4'h1;
        repeat (5) step();
        alu_cout = 1'b1;
        step();
        alu_cout = 1'b0;
        chk("mid_carry_set", 32'({ts0, carry0}), 32'({T1, 1'b1}));
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst", 32'({ts0, carry0}), 32'({T1, 1'b0}));

        // EARLY_END = 0 instance: OUT and LDA always take six T-states
        ee0_ts  = '{T1, T2, T3, T4, T5, T6, T1};
        ee0_exp = '{PCO | MARL, PCI, RAMO | IRL, AO | OUTL, 13'h0, 13'h0, PCO | MARL};
        opcode = 4'he;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("ee0_out%0d", k), 32'({ts1, ctrl1}), 32'({ee0_ts[k], ee0_exp[k]}));
            step();
        end
        opcode = 4'h0;
        ee0_exp = '{PCI, RAMO | IRL, IRO | MARL, RAMO | AL, 13'h0, PCO | MARL, PCI};
        ee0_ts  = '{T2, T3, T4, T5, T6, T1, T2};
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("ee0_lda%0d", k), 32'({ts1, ctrl1}), 32'({ee0_ts[k], ee0_exp[k]}));
            step();
        end

        // Sweep every opcode on both instances under the bus monitor
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int op = 0; op < 16; op++) begin
            opcode = 4'(op);
            for (int k = 0; k < 6; k++) begin
                alu_cout = 1'($urandom_range(0, 1));
                step();
            end
        end
        chk("sweep_halted", 32'({halted0, halted1}), 32'(2'b11));

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Microprogrammed control sequencer for the 8-bit CPU; drives the ALU/accumulator datapath, PC, MAR, RAM, IR and output register over the shared 8-bit bus.
- Runs fetch T1–T3 and execute T4–T6 per opcode.
- Holds the carry flag captured from the ALU adder carry-out.
- Provides single-step hold (run) and halt.

Parameters:
- OPC_W, 4, opcode width (IR upper nibble)
- EARLY_END, 1, 1 = return to T1 right after an instruction's last active T-state; 0 = always run all six T-states

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- run  input  1  1 = advance one T-state per clock; 0 = hold state and outputs
- opcode  input  OPC_W  current IR upper nibble, valid from T4
- alu_cout  input  1  ALU adder carry-out
- pc_out_en  output  1  PC drives bus
- pc_inc  output  1  PC increment
- pc_load  output  1  PC loads from bus
- mar_load  output  1  MAR loads from bus
- ram_out_en  output  1  RAM drives bus
- ir_load  output  1  IR loads from bus
- ir_out_en  output  1  IR operand nibble drives bus
- a_load  output  1  accumulator loads from bus
- a_out_en  output  1  accumulator drives bus
- b_load  output  1  B register loads from bus
- alu_sub  output  1  ALU operation select: 1 = subtract, 0 = add
- alu_out_en  output  1  ALU result drives bus (tri-state enable)
- out_load  output  1  output register loads from bus
- carry_flag  output  1  registered carry
- halted  output  1  CPU halted
- t_state  output  6  one-hot T-state; bit0 = T1

Behaviour:
- Reset, when rst_n = 0 at a clock edge:
  - t_state = 6'b000001, carry_flag = 0, halted = 0.
  - While rst_n is low, all control outputs are forced to 0.
- Control outputs are combinational decode of t_state, opcode and carry_flag, gated by (rst_n & ~halted).
- run = 0: t_state, carry_flag and halted hold. Control outputs still reflect the current state; the datapath relies on this for single-step operation.
- Fetch, all opcodes:
  - T1: pc_out_en, mar_load.
  - T2: pc_inc.
  - T3: ram_out_en, ir_load.
- Execute, by opcode:
  - LDA 0000: T4 ir_out_en, mar_load; T5 ram_out_en, a_load; last = T5.
  - ADD 0001: T4 ir_out_en, mar_load; T5 ram_out_en, b_load; T6 alu_out_en, a_load, alu_sub = 0; last = T6.
  - SUB 0010: same as ADD but alu_sub = 1 in T6; last = T6.
  - JMP 0110: T4 ir_out_en, pc_load; last = T4.
  - JC 0111: T4 ir_out_en and pc_load only if carry_flag = 1; last = T4.
  - OUT 1110: T4 a_out_en, out_load; last = T4.
  - HLT 1111: T4 produces no control outputs; halted is set at the T4 edge.
  - All other opcodes: NOP, last = T4.
- State advance, on a clock edge with run = 1 and not halted:
  - EARLY_END = 1: if the current state is the opcode's last T-state, go to T1; otherwise rotate left.
  - EARLY_END = 0: always rotate left; T6 wraps to T1.
  - T1–T3 are never shortened.
- Carry capture: at the edge ending T6 of ADD or SUB with run = 1, carry_flag <= alu_cout. Otherwise carry_flag holds. JC reads the value registered by the most recent ADD/SUB.
- Halt:
  - halted is sticky; t_state freezes at T4; all control outputs read 0.
  - Only reset clears halted. run is ignored while halted.
- Bus invariant: at most one of pc_out_en, ram_out_en, ir_out_en, a_out_en, alu_out_en is 1 in any cycle.
- Reset mid-instruction: takes priority over run and halted; the next cycle after release is T1 with carry cleared.
- t_state is always exactly one-hot. An illegal encoding recovers to T1 on the next edge.

Test Plan:
- Reset, then LDA: rst_n low 2 cycles, then opcode = 0000, run = 1 → T1 shows pc_out_en = mar_load = 1; T3 shows ram_out_en = ir_load = 1; T5 shows a_load = 1; with EARLY_END = 1 the next state is T1, so 5 cycles per instruction.
- ADD sets carry: opcode = 0001, alu_cout = 1 during T6 → T6 shows alu_out_en = a_load = 1 and alu_sub = 0; carry_flag = 1 on the next cycle.
- SUB then JC: opcode = 0010 with alu_cout = 0 at T6 → alu_sub = 1 in T6 and carry_flag = 0. Next instruction JC (0111) → pc_load = 0 in T4. Repeat with alu_cout = 1 → pc_load = ir_out_en = 1 in T4.
- Run hold: drop run at T5 of ADD for 3 cycles → t_state stays 6'b010000 with b_load = 1 held; resumes to T6 when run = 1.
- HLT: opcode = 1111 → halted = 1 after the T4 edge; all controls 0 for 10+ cycles; t_state = 6'b001000. rst_n pulse → halted = 0, T1.
- EARLY_END = 0 with OUT (1110): T4 shows a_out_en = out_load = 1; T5 and T6 have no outputs; 6 cycles per instruction. Bus-invariant assertion is checked every cycle across all opcodes 0–15.
